pwm_signal_generator: RTL and testbench

//   Tiny-Tapeout-style 8-bit PWM generator: free-running counter behind a power-of-two

---
 rtl/pwm_pkg.sv | 35 +++
 rtl/pwm_deadtime.sv | 53 +++++
 rtl/pwm_signal_generator.sv | 104 ++++++++++
 tb/tb_pwm_signal_generator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the 8-bit PWM generator: widths, uio_in bit positions,
// prescaler mask helper and the dead-time length table.
package pwm_pkg;

   localparam int CNT_W       = 8;
   localparam int PRESC_W     = 15;
   localparam int DT_W        = 4;

   localparam int UIO_P_LSB   = 0;
   localparam int UIO_P_W     = 4;
   localparam int UIO_INV_BIT = 4;
   localparam int UIO_RUN_BIT = 5;
   localparam int UIO_DT_LSB  = 6;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Terminal prescaler count for divide-by-2**p; p=15 still fits PRESC_W bits.
   function automatic logic [PRESC_W-1:0] presc_mask(input logic [UIO_P_W-1:0] p);
      logic [PRESC_W:0] full;
      full = ((PRESC_W+1)'(1) << p) - (PRESC_W+1)'(1);
      return full[PRESC_W-1:0];
   endfunction

   function automatic logic [DT_W-1:0] dt_lookup(input logic [1:0] sel);
      logic [DT_W-1:0] len;
      case (sel)
         2'd0:    len = 4'd0;
         2'd1:    len = 4'd2;
         2'd2:    len = 4'd4;
         default: len = 4'd8;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: after any change of the registered PWM pair, both outputs
// are blanked for the selected number of clocks; pulses shorter than that vanish.
module pwm_deadtime
   import pwm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] dt_sel,
   input  logic       pwm_raw,
   input  logic       pwm_n_raw,
   output logic       pwm,
   output logic       pwm_n
);

   logic            prev_q, prev_d;
   logic            prev_n_q, prev_n_d;
   logic [DT_W-1:0] dt_q, dt_d;
   logic [DT_W-1:0] dt_len;
   logic            edge_seen;
   logic            blank;

   always_comb begin
      dt_len    = dt_lookup(dt_sel);
      prev_d    = pwm_raw;
      prev_n_d  = pwm_n_raw;
      edge_seen = (pwm_raw != prev_q) || (pwm_n_raw != prev_n_q);
      blank     = 1'b0;
      dt_d      = dt_q;
      // The edge cycle itself counts as the first blanked clock.
      if (edge_seen) begin
         blank = (dt_len != '0);
         dt_d  = (dt_len != '0) ? dt_len - 4'd1 : '0;
      end else if (dt_q != '0) begin
         blank = 1'b1;
         dt_d  = dt_q - 4'd1;
      end
      pwm   = pwm_raw & ~blank;
      pwm_n = pwm_n_raw & ~blank;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= 1'b0;
         prev_n_q <= 1'b0;
         dt_q     <= '0;
      end else begin
         prev_q   <= prev_d;
         prev_n_q <= prev_n_d;
         dt_q     <= dt_d;
      end
   end

endmodule

// File: rtl/pwm_signal_generator.sv
// Tiny-Tapeout-style 8-bit PWM: prescaled free-running counter vs double-buffered duty.
// Define PWM_DEADTIME_EN to insert selectable dead time between pwm and pwm_n.
module pwm_signal_generator
   import pwm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   duty_q, duty_d;
   logic               pwm_q, pwm_d;
   logic               pwm_n_q, pwm_n_d;
   logic               strobe_q, strobe_d;

   logic [UIO_P_W-1:0] p;
   logic               invert;
   logic               run;
   logic [1:0]         dt_sel;
   logic               tick;
   logic               wrap;
   logic               level;
   logic               pwm_out;
   logic               pwm_n_out;

   always_comb begin
      p      = uio_in[UIO_P_LSB +: UIO_P_W];
      invert = uio_in[UIO_INV_BIT];
      run    = uio_in[UIO_RUN_BIT];
      dt_sel = uio_in[UIO_DT_LSB +: 2];
      // ">=" so a smaller p taking effect mid-count ticks early instead of wrapping presc.
      tick   = ena && run && (presc_q >= presc_mask(p));
      wrap   = tick && (cnt_q == CNT_MAX);
      level  = (cnt_q < duty_q) ^ invert;

      presc_d  = presc_q;
      cnt_d    = cnt_q;
      duty_d   = duty_q;
      pwm_d    = run & level;
      pwm_n_d  = run & ~level;
      strobe_d = wrap;

      if (!ena) begin
         presc_d = presc_q;
      end else if (!run) begin
         presc_d = '0;
         cnt_d   = '0;
         duty_d  = ui_in;
      end else begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
         cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;
         if (wrap) begin
            duty_d = ui_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         duty_q   <= '0;
         pwm_q    <= 1'b0;
         pwm_n_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         pwm_q    <= pwm_d;
         pwm_n_q  <= pwm_n_d;
         strobe_q <= strobe_d;
      end
   end

`ifdef PWM_DEADTIME_EN
   pwm_deadtime u_deadtime (
      .clk       (clk),
      .rst       (rst),
      .dt_sel    (dt_sel),
      .pwm_raw   (pwm_q),
      .pwm_n_raw (pwm_n_q),
      .pwm       (pwm_out),
      .pwm_n     (pwm_n_out)
   );
`else
   logic unused_dt_sel;
   assign unused_dt_sel = ^dt_sel;
   assign pwm_out       = pwm_q;
   assign pwm_n_out     = pwm_n_q;
`endif

   assign uo_out  = ena ? {cnt_q[CNT_W-1:3], strobe_q, pwm_n_out, pwm_out} : 8'h00;
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_pwm_signal_generator.sv
// Bench for pwm_signal_generator: arithmetic period model checked every cycle,
// plus directed high-time / strobe / freeze expectations computed by hand.
module tb_pwm_signal_generator;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic [3:0] p;
   logic       inv;
   logic       run;
   logic [1:0] dt_sel;

   int total = 0;
   int bad   = 0;

   assign uio_in = {dt_sel, run, inv, p};

   always #5 clk = ~clk;

   pwm_signal_generator dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: n = enabled running clocks since the run began; counter = n / 2**p mod 256.
   longint     m_n     = 0;
   logic [7:0] m_duty  = 8'h00;
   logic       m_pwm   = 1'b0;
   logic       m_pwmn  = 1'b0;
   logic       m_stb   = 1'b0;
   logic       m_prev  = 1'b0;
   logic       m_prevn = 1'b0;
   int         m_age   = 1000;
   bit         m_valid = 1'b0;
   int         dt_tab[4] = '{0, 2, 4, 8};

   function automatic logic [7:0] model_cnt();
      return 8'((m_n >> p) % 256);
   endfunction

   always @(posedge clk) begin
      logic lvl;
      lvl = (model_cnt() < m_duty) ^ inv;
      if (rst) begin
         m_n = 0; m_duty = 8'h00; m_pwm = 1'b0; m_pwmn = 1'b0; m_stb = 1'b0;
         m_valid = 1'b1;
      end else if (!ena) begin
         m_pwm = run & lvl; m_pwmn = run & ~lvl; m_stb = 1'b0;
      end else if (!run) begin
         m_n = 0; m_duty = ui_in; m_pwm = 1'b0; m_pwmn = 1'b0; m_stb = 1'b0;
      end else begin
         m_pwm  = lvl;
         m_pwmn = ~lvl;
         m_n    = m_n + 1;
         m_stb  = ((m_n % (longint'(256) << p)) == 0);
         if (m_stb) m_duty = ui_in;
      end
      if (rst) m_age = 1000;
      else if (m_pwm != m_prev || m_pwmn != m_prevn) m_age = 0;
      else if (m_age < 1000) m_age++;
      m_prev  = m_pwm;
      m_prevn = m_pwmn;
   end

   always @(posedge clk) begin
      logic [7:0] cnt;
      logic       ep, epn;
      logic [7:0] exp_uo;
      #2;
      if (m_valid) begin
         cnt = model_cnt();
         ep  = m_pwm;
         epn = m_pwmn;
`ifdef PWM_DEADTIME_EN
         ep  = m_pwm  & (m_age >= dt_tab[dt_sel]);
         epn = m_pwmn & (m_age >= dt_tab[dt_sel]);
`endif
         exp_uo = ena ? {cnt[7:3], m_stb, epn, ep} : 8'h00;
         check("cycle_uo_out", 32'(uo_out), 32'(exp_uo));
         check("cycle_uio_const", 32'({uio_out, uio_oe}), 32'h0);
      end
   end

   task automatic wait_strobe(input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!uo_out[2] && k < budget);
      check("strobe_wait", 32'(uo_out[2]), 32'h1);
   endtask

   task automatic measure(input int ncyc, output int hi, output int nhi, output int stb,
                          output int steps);
      logic [4:0] prev_c;
      hi = 0; nhi = 0; stb = 0; steps = 0;
      prev_c = uo_out[7:3];
      repeat (ncyc) begin
         @(negedge clk);
         hi  += int'(uo_out[0]);
         nhi += int'(uo_out[1]);
         stb += int'(uo_out[2]);
         if (uo_out[7:3] != prev_c) steps++;
         prev_c = uo_out[7:3];
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, nhi, stb, steps, h1, h2;
      rst = 1'b1; ena = 1'b1; ui_in = 8'd0; p = 4'd0; inv = 1'b0; run = 1'b0; dt_sel = 2'd0;
      repeat (2) @(negedge clk);
      check("reset_uo_out", 32'(uo_out), 32'h0);
      rst = 1'b0;

      // duty 64, p=0: 64 high / 192 low, one strobe per 256 clocks
      ui_in = 8'd64; run = 1'b1;
      wait_strobe(600);
      measure(256, hi, nhi, stb, steps);
      check("d64_high", hi, 64);
      check("d64_low_n", nhi, 192);
      check("d64_strobes", stb, 1);
      measure(256, hi, nhi, stb, steps);
      check("d64_high_2", hi, 64);
      check("d64_strobes_2", stb, 1);

      // duty extremes
      ui_in = 8'd0;
      wait_strobe(300);
      measure(256, hi, nhi, stb, steps);
      check("d0_high", hi, 0);
      check("d0_n_high", nhi, 256);
      ui_in = 8'd255;
      wait_strobe(300);
      measure(256, hi, nhi, stb, steps);
      check("d255_high", hi, 255);
      check("d255_n_high", nhi, 1);

      // duty change mid-period is deferred to the next period
      ui_in = 8'd64;
      wait_strobe(300);
      measure(100, h1, nhi, stb, steps);
      ui_in = 8'd192;
      measure(156, h2, nhi, stb, steps);
      check("midchange_cur_high", h1 + h2, 64);
      measure(256, hi, nhi, stb, steps);
      check("midchange_next_high", hi, 192);

      // p=2: 1024-clock period, counter field steps every 32 clocks
      run = 1'b0; p = 4'd2; ui_in = 8'd128;
      @(negedge clk);
      run = 1'b1;
      wait_strobe(1100);
      measure(1024, hi, nhi, stb, steps);
      check("p2_high", hi, 512);
      check("p2_steps", steps, 32);
      check("p2_strobes", stb, 1);

      // invert
      run = 1'b0; p = 4'd0; inv = 1'b1; ui_in = 8'd64;
      @(negedge clk);
      run = 1'b1;
      wait_strobe(300);
      measure(256, hi, nhi, stb, steps);
      check("inv_high", hi, 192);
      check("inv_n_high", nhi, 64);

      // ena freeze, run clear, reset mid-period
      inv = 1'b0;
      wait_strobe(300);
      repeat (50) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      check("ena_off_uo", 32'(uo_out), 32'h0);
      repeat (10) @(negedge clk);
      check("ena_off_hold_uo", 32'(uo_out), 32'h0);
      ena = 1'b1;
      repeat (20) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      check("run_off_uo", 32'(uo_out), 32'h0);
      run = 1'b1;
      repeat (100) @(negedge clk);
      check("restart_cnt_field", 32'(uo_out[7:3]), 32'd12);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_uo", 32'(uo_out), 32'h0);
      rst = 1'b0;

`ifdef PWM_DEADTIME_EN
      // 4-clock gap after each edge: both pulses lose their first 4 clocks
      dt_sel = 2'd2; ui_in = 8'd64;
      wait_strobe(600);
      wait_strobe(300);
      measure(256, hi, nhi, stb, steps);
      check("dt4_high", hi, 60);
      check("dt4_n_high", nhi, 188);
`else
      // dead-time select has no effect without the option
      dt_sel = 2'd3; ui_in = 8'd64;
      wait_strobe(600);
      wait_strobe(300);
      measure(256, hi, nhi, stb, steps);
      check("dtsel_ignored_high", hi, 64);
      check("dtsel_ignored_n_high", nhi, 192);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
